// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII Ethernet receive/transmit path.
package ether_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 advance by one RMII dibit (bit 0 first).
module crc32_dibit
  import ether_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] crc_mid;

  assign crc_mid = (crc_in[0] ^ dibit[0]) ? ((crc_in >> 1) ^ CRC_POLY) : (crc_in >> 1);
  assign crc_out = (crc_mid[0] ^ dibit[1]) ? ((crc_mid >> 1) ^ CRC_POLY) : (crc_mid >> 1);

endmodule

// File: rtl/ether_rx.sv
// RMII receiver: preamble/SFD hunt, LSB-first byte assembly, CRC-32 check
// and a one-cycle frame-end status strobe.
module ether_rx
  import ether_pkg::*;
#(
  parameter int MIN_PREAMBLE = 16,
  parameter int MAX_BYTES    = 1522,
  parameter int CNT_W        = 11
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             crsdv_in,
  input  logic [1:0]       rxd_in,
  output logic             axiov,
  output logic [7:0]       axiod,
  output logic             frame_done,
  output logic             fcs_ok,
  output logic [CNT_W-1:0] byte_count,
  output rx_state_t        dbg_state
);

  localparam int               PRE_W    = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PRE_W-1:0] PRE_MIN  = PRE_W'(MIN_PREAMBLE);
  localparam logic [CNT_W-1:0] BYTE_MAX = CNT_W'(MAX_BYTES);

  rx_state_t        state;
  logic             crsdv_q;
  logic [1:0]       rxd_q;
  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       dibit_idx;
  logic [5:0]       byte_sr;
  logic [31:0]      crc;
  logic [31:0]      crc_next;

  crc32_dibit u_crc (
    .crc_in  (crc),
    .dibit   (rxd_q),
    .crc_out (crc_next)
  );

  assign dbg_state = state;

  // axiov/axiod is a pure strobe stream: no ready, the consumer must take
  // every byte in the cycle axiov is high.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      crsdv_q    <= 1'b0;
      rxd_q      <= 2'b00;
      pre_cnt    <= '0;
      dibit_idx  <= 2'd0;
      byte_sr    <= 6'd0;
      crc        <= 32'd0;
      axiov      <= 1'b0;
      axiod      <= 8'd0;
      frame_done <= 1'b0;
      fcs_ok     <= 1'b0;
      byte_count <= '0;
    end else begin
      crsdv_q    <= crsdv_in;
      rxd_q      <= rxd_in;
      axiov      <= 1'b0;
      frame_done <= 1'b0;
      fcs_ok     <= 1'b0;
      case (state)
        IDLE: begin
          if (crsdv_q) begin
            if (rxd_q == PREAMBLE_DIBIT) begin
              state   <= PREAMBLE;
              pre_cnt <= PRE_W'(1);
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!crsdv_q) begin
            state <= IDLE;
          end else if (rxd_q == PREAMBLE_DIBIT) begin
            if (pre_cnt != '1) pre_cnt <= pre_cnt + PRE_W'(1);
          end else if (rxd_q == SFD_DIBIT && pre_cnt >= PRE_MIN) begin
            state      <= DATA;
            crc        <= CRC_INIT;
            dibit_idx  <= 2'd0;
            byte_count <= '0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!crsdv_q) begin
            frame_done <= 1'b1;
            fcs_ok     <= (crc == CRC_RESIDUE) && (dibit_idx == 2'd0) &&
                          (byte_count >= CNT_W'(4));
            state      <= IDLE;
          end else begin
            crc       <= crc_next;
            dibit_idx <= dibit_idx + 2'd1;
            byte_sr   <= {rxd_q, byte_sr[5:2]};
            if (dibit_idx == 2'd3) begin
              // A byte beyond the length limit aborts the frame instead of emitting.
              if (byte_count == BYTE_MAX) begin
                frame_done <= 1'b1;
                state      <= DROP;
              end else begin
                axiov      <= 1'b1;
                axiod      <= {rxd_q, byte_sr};
                byte_count <= byte_count + CNT_W'(1);
              end
            end
          end
        end
        DROP: begin
          if (!crsdv_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx.sv
// Randomized frame-level bench for ether_rx with a byte-oriented CRC reference.
module tb_ether_rx;
  import ether_pkg::*;

  localparam int MAXB = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        crsdv_in;
  logic [1:0]  rxd_in;
  logic        axiov;
  logic [7:0]  axiod;
  logic        frame_done;
  logic        fcs_ok;
  logic [10:0] byte_count;
  rx_state_t   dbg_state;

  ether_rx #(.MIN_PREAMBLE(16), .MAX_BYTES(MAXB), .CNT_W(11)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .crsdv_in   (crsdv_in),
    .rxd_in     (rxd_in),
    .axiov      (axiov),
    .axiod      (axiod),
    .frame_done (frame_done),
    .fcs_ok     (fcs_ok),
    .byte_count (byte_count),
    .dbg_state  (dbg_state)
  );

  always #10 clk_in = ~clk_in;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  frame_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        fd_fcs_q[$];
  logic [10:0] fd_bc_q[$];
  logic        exp_fcs_q[$];
  int          exp_bc_q[$];

  // Monitor: collect strobes away from the rising edge.
  always @(negedge clk_in) begin
    if (rst_in === 1'b1) begin
      if (axiov === 1'b1) got_q.push_back(axiod);
      if (frame_done === 1'b1) begin
        fd_fcs_q.push_back(fcs_ok);
        fd_bc_q.push_back(byte_count);
        total++;
        if (axiov !== 1'b0) begin
          bad++;
          $display("FAIL overlap axiov=%b with frame_done, required 0", axiov);
        end
      end
    end
  end

  function automatic logic [31:0] crc_of_frame();
    logic [31:0] c;
    c = CRC_INIT;
    foreach (frame_q[i]) begin
      c = c ^ {24'd0, frame_q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic model_fcs(input int n_extra);
    return (crc_of_frame() == CRC_RESIDUE) && (n_extra == 0) &&
           (frame_q.size() >= 4) && (frame_q.size() <= MAXB);
  endfunction

  task automatic build_frame(input int n_payload);
    logic [31:0] c;
    frame_q.delete();
    repeat (n_payload) frame_q.push_back(8'($urandom));
    c = ~crc_of_frame();
    for (int k = 0; k < 4; k++) frame_q.push_back(c[8*k +: 8]);
  endtask

  // Record what the model says this frame should produce.
  task automatic expect_frame(input int n_extra);
    for (int i = 0; i < frame_q.size() && i < MAXB; i++) exp_q.push_back(frame_q[i]);
    exp_fcs_q.push_back(model_fcs(n_extra));
    exp_bc_q.push_back(frame_q.size() < MAXB ? frame_q.size() : MAXB);
  endtask

  task automatic clear_all();
    got_q.delete(); fd_fcs_q.delete(); fd_bc_q.delete();
    exp_q.delete(); exp_fcs_q.delete(); exp_bc_q.delete();
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    @(negedge clk_in);
    crsdv_in = dv;
    rxd_in   = d;
  endtask

  task automatic send_frame(input int n_pre, input int n_bytes, input int n_extra, input int n_gap);
    logic [7:0] b;
    repeat (n_pre) drive(1'b1, PREAMBLE_DIBIT);
    drive(1'b1, SFD_DIBIT);
    for (int i = 0; i < n_bytes; i++) begin
      b = frame_q[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    repeat (n_extra) drive(1'b1, 2'($urandom));
    repeat (n_gap) drive(1'b0, 2'b00);
  endtask

  // Compare everything collected against the model's expectations.
  task automatic test_compare_frames(input string name);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_nbytes got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_byte[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (fd_fcs_q.size() != exp_fcs_q.size()) begin
      bad++;
      $display("FAIL %s_nframes got=%0d exp=%0d", name, fd_fcs_q.size(), exp_fcs_q.size());
    end
    for (int i = 0; i < exp_fcs_q.size() && i < fd_fcs_q.size(); i++) begin
      total += 2;
      if (fd_fcs_q[i] !== exp_fcs_q[i]) begin
        bad++;
        $display("FAIL %s_fcs[%0d] got=%b exp=%b", name, i, fd_fcs_q[i], exp_fcs_q[i]);
      end
      if (fd_bc_q[i] !== 11'(exp_bc_q[i])) begin
        bad++;
        $display("FAIL %s_bc[%0d] got=%0d exp=%0d", name, i, fd_bc_q[i], exp_bc_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; crsdv_in = 1'b0; rxd_in = 2'b00;
    repeat (3) @(negedge clk_in);
    total += 6;
    if (axiov !== 1'b0)       begin bad++; $display("FAIL rst_axiov got=%b exp=0", axiov); end
    if (axiod !== 8'd0)       begin bad++; $display("FAIL rst_axiod got=%h exp=00", axiod); end
    if (frame_done !== 1'b0)  begin bad++; $display("FAIL rst_fd got=%b exp=0", frame_done); end
    if (fcs_ok !== 1'b0)      begin bad++; $display("FAIL rst_fcs got=%b exp=0", fcs_ok); end
    if (byte_count !== 11'd0) begin bad++; $display("FAIL rst_bc got=%0d exp=0", byte_count); end
    if (dbg_state !== IDLE)   begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_good_frame();
    clear_all();
    build_frame(60);
    expect_frame(0);
    send_frame(28, frame_q.size(), 0, 4);
    test_compare_frames("good");
  endtask

  task automatic test_bad_crc();
    int idx;
    clear_all();
    build_frame(60);
    idx = $urandom_range(0, 59);
    frame_q[idx] = frame_q[idx] ^ 8'(1 << $urandom_range(0, 7));
    expect_frame(0);
    send_frame($urandom_range(16, 30), frame_q.size(), 0, 4);
    test_compare_frames("badcrc");
  endtask

  task automatic test_short_preamble();
    clear_all();
    build_frame(20);
    send_frame(8, frame_q.size(), 0, 4);
    build_frame(12);
    send_frame(15, frame_q.size(), 0, 4);
    test_compare_frames("shortpre");
  endtask

  task automatic test_boundaries();
    clear_all();
    build_frame(0);
    expect_frame(0);
    send_frame(16, frame_q.size(), 0, 1);
    frame_q.delete();
    repeat (3) frame_q.push_back(8'($urandom));
    expect_frame(0);
    send_frame(20, frame_q.size(), 0, 4);
    test_compare_frames("bound");
  endtask

  task automatic test_partial();
    clear_all();
    build_frame($urandom_range(20, 50));
    expect_frame(3);
    send_frame(24, frame_q.size(), 3, 4);
    test_compare_frames("partial");
  endtask

  task automatic test_overflow();
    clear_all();
    build_frame(66);
    expect_frame(0);
    send_frame(20, frame_q.size(), 0, 4);
    test_compare_frames("overflow");
  endtask

  task automatic test_reset_mid();
    clear_all();
    build_frame(56);
    send_frame(20, 20, 0, 0);
    @(negedge clk_in);
    rst_in = 1'b0; crsdv_in = 1'b0; rxd_in = 2'b00;
    #1;
    total += 5;
    if (axiov !== 1'b0)       begin bad++; $display("FAIL midrst_axiov got=%b exp=0", axiov); end
    if (axiod !== 8'd0)       begin bad++; $display("FAIL midrst_axiod got=%h exp=00", axiod); end
    if (frame_done !== 1'b0)  begin bad++; $display("FAIL midrst_fd got=%b exp=0", frame_done); end
    if (byte_count !== 11'd0) begin bad++; $display("FAIL midrst_bc got=%0d exp=0", byte_count); end
    if (dbg_state !== IDLE)   begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, IDLE); end
    @(negedge clk_in);
    rst_in = 1'b1;
    clear_all();
    build_frame(60);
    expect_frame(0);
    send_frame(28, frame_q.size(), 0, 4);
    test_compare_frames("afterrst");
  endtask

  task automatic test_back_to_back();
    clear_all();
    for (int f = 0; f < 3; f++) begin
      build_frame($urandom_range(1, 50));
      expect_frame(0);
      send_frame($urandom_range(16, 24), frame_q.size(), 0, (f == 2) ? 4 : 1);
    end
    test_compare_frames("b2b");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_short_preamble();
    test_boundaries();
    test_partial();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
